// File: rtl/eth_pkt_arb_pkg.sv
// Shared types and helpers for the eth_pkt_if round-robin arbiter.
// rr_pick works on a fixed MAX_CH-wide vector so one function serves every CH_CNT.
package eth_pkt_arb_pkg;

  typedef enum logic {IDLE, PASS} arb_state_t;

  localparam int MAX_CH = 8;

  // Valid-byte-count width for a given data width; never narrower than 1 bit.
  function automatic int mod_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 1;
  endfunction

  // One-hot pick of the first requester strictly after the last grant, wrapping at ch_cnt.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [MAX_CH-1:0] last,
                                                input int ch_cnt);
    int   last_idx;
    int   k;
    logic found;
    last_idx = 0;
    found    = 1'b0;
    rr_pick  = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < ch_cnt && last[i]) last_idx = i;
    end
    for (int i = 1; i <= MAX_CH; i++) begin
      k = (last_idx + i) % ch_cnt;
      if (i <= ch_cnt && !found && req[k]) begin
        rr_pick[k] = 1'b1;
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/eth_pkt_if.sv
// Packet stream bundle: data/val/sop/eop/mod forward, ready backward.
interface eth_pkt_if #(
  parameter int DATA_W = 64,
  parameter int MOD_W  = 3
);
  logic [DATA_W-1:0] data;
  logic              val;
  logic              sop;
  logic              eop;
  logic [MOD_W-1:0]  mod;
  logic              ready;

  modport o (output data, val, sop, eop, mod, input ready);
  modport i (input data, val, sop, eop, mod, output ready);
endinterface

// File: rtl/eth_pkt_if_reg_slice.sv
// Two-entry skid buffer for a packet stream: registered outputs, and input ready
// depends only on local state so downstream ready never reaches upstream combinationally.
module eth_pkt_if_reg_slice #(
  parameter int DATA_W = 64,
  parameter int MOD_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_val,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [MOD_W-1:0]  in_mod,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_val,
  output logic              out_sop,
  output logic              out_eop,
  output logic [MOD_W-1:0]  out_mod,
  input  logic              out_ready
);

  logic [DATA_W-1:0] out_data_reg;
  logic              out_val_reg;
  logic              out_sop_reg;
  logic              out_eop_reg;
  logic [MOD_W-1:0]  out_mod_reg;

  logic [DATA_W-1:0] skid_data_reg;
  logic              skid_val_reg;
  logic              skid_sop_reg;
  logic              skid_eop_reg;
  logic [MOD_W-1:0]  skid_mod_reg;

  logic in_fire;
  logic out_load;

  assign in_ready = ~skid_val_reg;
  assign in_fire  = in_val & in_ready;
  assign out_load = out_ready | ~out_val_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_reg  <= '0;
      out_val_reg   <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_mod_reg   <= '0;
      skid_data_reg <= '0;
      skid_val_reg  <= 1'b0;
      skid_sop_reg  <= 1'b0;
      skid_eop_reg  <= 1'b0;
      skid_mod_reg  <= '0;
    end else if (out_load) begin
      if (skid_val_reg) begin
        // Parked word goes first; input is held off while the skid entry is full.
        out_data_reg <= skid_data_reg;
        out_val_reg  <= 1'b1;
        out_sop_reg  <= skid_sop_reg;
        out_eop_reg  <= skid_eop_reg;
        out_mod_reg  <= skid_mod_reg;
        skid_val_reg <= 1'b0;
      end else begin
        out_data_reg <= in_data;
        out_val_reg  <= in_fire;
        out_sop_reg  <= in_sop & in_fire;
        out_eop_reg  <= in_eop & in_fire;
        out_mod_reg  <= in_mod;
      end
    end else if (in_fire) begin
      skid_data_reg <= in_data;
      skid_val_reg  <= 1'b1;
      skid_sop_reg  <= in_sop;
      skid_eop_reg  <= in_eop;
      skid_mod_reg  <= in_mod;
    end
  end

  assign out_data = out_data_reg;
  assign out_val  = out_val_reg;
  assign out_sop  = out_sop_reg;
  assign out_eop  = out_eop_reg;
  assign out_mod  = out_mod_reg;

endmodule

// File: rtl/eth_pkt_if_rr_arbiter.sv
// Packet-level round-robin merge of CH_CNT packet streams; the grant is held from sop
// to eop so packets never interleave, and non-sop words seen while idle are dropped.
module eth_pkt_if_rr_arbiter
  import eth_pkt_arb_pkg::*;
#(
  parameter int CH_CNT = 2,
  parameter int DATA_W = 64,
  parameter int MOD_W  = mod_w(DATA_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CH_CNT*DATA_W-1:0] in_data_i,
  input  logic [CH_CNT-1:0]        in_val_i,
  input  logic [CH_CNT-1:0]        in_sop_i,
  input  logic [CH_CNT-1:0]        in_eop_i,
  input  logic [CH_CNT*MOD_W-1:0]  in_mod_i,
  output logic [CH_CNT-1:0]        in_ready_o,
  eth_pkt_if.o                     pkt_o,
  output logic [CH_CNT-1:0]        grant_o,
  output logic                     orphan_err_o
);

  arb_state_t        state_reg, state_next;
  logic [CH_CNT-1:0] grant_reg, grant_next;
  logic [MAX_CH-1:0] rr_reg, rr_next;

  logic [CH_CNT-1:0] req;
  logic [CH_CNT-1:0] orphan;
  logic [MAX_CH-1:0] pick;

  logic [DATA_W-1:0] ch_data [CH_CNT];
  logic [MOD_W-1:0]  ch_mod  [CH_CNT];
  logic [DATA_W-1:0] sel_data;
  logic [MOD_W-1:0]  sel_mod;
  logic              sel_val;
  logic              sel_sop;
  logic              sel_eop;

  logic              slice_in_val;
  logic              slice_ready;
  logic [DATA_W-1:0] slice_data;
  logic              slice_val;
  logic              slice_sop;
  logic              slice_eop;
  logic [MOD_W-1:0]  slice_mod;

  assign req    = in_val_i & in_sop_i;
  assign orphan = in_val_i & ~in_sop_i;
  assign pick   = rr_pick(MAX_CH'(req), rr_reg, CH_CNT);

  for (genvar gi = 0; gi < CH_CNT; gi++) begin : g_ch
    assign ch_data[gi] = grant_reg[gi] ? in_data_i[gi*DATA_W +: DATA_W] : '0;
    assign ch_mod[gi]  = grant_reg[gi] ? in_mod_i[gi*MOD_W +: MOD_W] : '0;
  end

  // Grant is one-hot or zero, so an OR of masked lanes is the mux.
  always_comb begin
    sel_data = '0;
    sel_mod  = '0;
    for (int k = 0; k < CH_CNT; k++) begin
      sel_data = sel_data | ch_data[k];
      sel_mod  = sel_mod | ch_mod[k];
    end
  end

  assign sel_val = |(grant_reg & in_val_i);
  assign sel_sop = |(grant_reg & in_sop_i);
  assign sel_eop = |(grant_reg & in_eop_i);

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_next      = rr_reg;
    in_ready_o   = '0;
    orphan_err_o = 1'b0;
    slice_in_val = 1'b0;
    // Handshake outputs stay quiet while reset is held.
    if (!rst_i) begin
      case (state_reg)
        IDLE: begin
          in_ready_o   = orphan;
          orphan_err_o = |orphan;
          if (|req) begin
            grant_next = pick[CH_CNT-1:0];
            rr_next    = pick;
            state_next = PASS;
          end
        end
        PASS: begin
          in_ready_o   = grant_reg & {CH_CNT{slice_ready}};
          slice_in_val = sel_val;
          if (sel_val && slice_ready && sel_eop) begin
            grant_next = '0;
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      rr_reg    <= MAX_CH'(1) << (CH_CNT - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
    end
  end

  eth_pkt_if_reg_slice #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W)
  ) u_slice (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_data   (sel_data),
    .in_val    (slice_in_val),
    .in_sop    (sel_sop),
    .in_eop    (sel_eop),
    .in_mod    (sel_mod),
    .in_ready  (slice_ready),
    .out_data  (slice_data),
    .out_val   (slice_val),
    .out_sop   (slice_sop),
    .out_eop   (slice_eop),
    .out_mod   (slice_mod),
    .out_ready (pkt_o.ready)
  );

  assign pkt_o.data = slice_data;
  assign pkt_o.val  = slice_val;
  assign pkt_o.sop  = slice_sop;
  assign pkt_o.eop  = slice_eop;
  assign pkt_o.mod  = slice_mod;
  assign grant_o    = grant_reg;

endmodule

// File: tb/tb_eth_pkt_if_rr_arbiter.sv
// Directed bench for the round-robin packet arbiter: a per-cycle vector table plus
// hand-written sequences for fairness, back-pressure and mid-packet reset.
module tb_eth_pkt_if_rr_arbiter;

  localparam int CH = 2;
  localparam int DW = 64;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH*DW-1:0] in_data;
  logic [CH-1:0]    in_val;
  logic [CH-1:0]    in_sop;
  logic [CH-1:0]    in_eop;
  logic [CH*MW-1:0] in_mod;
  logic [CH-1:0]    in_ready;
  logic [CH-1:0]    grant;
  logic             orphan;

  eth_pkt_if #(.DATA_W(DW), .MOD_W(MW)) pkt_bus ();

  eth_pkt_if_rr_arbiter #(
    .CH_CNT (CH),
    .DATA_W (DW),
    .MOD_W  (MW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_data_i    (in_data),
    .in_val_i     (in_val),
    .in_sop_i     (in_sop),
    .in_eop_i     (in_eop),
    .in_mod_i     (in_mod),
    .in_ready_o   (in_ready),
    .pkt_o        (pkt_bus),
    .grant_o      (grant),
    .orphan_err_o (orphan)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  typedef struct packed {
    logic [1:0] val, sop, eop;
    logic [7:0] d0, d1;
    logic [2:0] m0, m1;
    logic [1:0] g, rdy;
    logic       orph, oval, osop, oeop;
    logic [7:0] od;
    logic [2:0] om;
  } vec_t;

  word_t got_q[$];
  int    cyc_q[$];
  int    r1_bad;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Stream source word: data encodes channel, packet number and word index.
  function automatic word_t mk_word(input int ch, input int p, input int w, input int len);
    word_t r;
    r.data = {40'h0, 8'(ch), 8'(p), 8'(w)};
    r.sop  = (w == 0);
    r.eop  = (w == len - 1);
    r.mod  = 3'(w + 1);
    return r;
  endfunction

  task automatic drive_idle();
    in_data = '0;
    in_val  = '0;
    in_sop  = '0;
    in_eop  = '0;
    in_mod  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    pkt_bus.ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both channels send np packets of len words back to back; collect accepted output words.
  task automatic stream(input int len, input int np0, input int np1, input bit toggle, input int want);
    int    w [CH];
    int    p [CH];
    int    np;
    word_t wd;
    got_q.delete();
    cyc_q.delete();
    r1_bad = 0;
    for (int k = 0; k < CH; k++) begin
      w[k] = 0;
      p[k] = 0;
    end
    for (int cyc = 0; cyc < 400 && got_q.size() < want; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        np = (k == 0) ? np0 : np1;
        wd = mk_word(k, p[k], w[k], len);
        in_val[k]           = (p[k] < np);
        in_sop[k]           = wd.sop;
        in_eop[k]           = wd.eop;
        in_data[k*DW +: DW] = wd.data;
        in_mod[k*MW +: MW]  = wd.mod;
      end
      pkt_bus.ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (grant == 2'b01 && in_ready[1]) r1_bad++;
      if (pkt_bus.val && pkt_bus.ready) begin
        got_q.push_back({pkt_bus.data, pkt_bus.sop, pkt_bus.eop, pkt_bus.mod});
        cyc_q.push_back(cyc);
        $display("out word %0d cyc %0d: data=%h sop=%b eop=%b mod=%0d",
                 got_q.size() - 1, cyc, pkt_bus.data, pkt_bus.sop, pkt_bus.eop, pkt_bus.mod);
      end
      for (int k = 0; k < CH; k++) begin
        if (in_val[k] && in_ready[k]) begin
          if (w[k] == len - 1) begin
            w[k] = 0;
            p[k]++;
          end else begin
            w[k]++;
          end
        end
      end
    end
    pkt_bus.ready = 1'b1;
  endtask

  task automatic chk_word(input string name, input word_t act, input word_t exp);
    chk({name, "_data"}, act.data, exp.data);
    chk({name, "_ctl"}, 64'({act.sop, act.eop, act.mod}), 64'({exp.sop, exp.eop, exp.mod}));
  endtask

  vec_t vecs [15];

  initial begin
    int    fired;
    word_t exp_w;

    //        val    sop    eop    d0     d1     m0    m1    g      rdy    or    ov    os    oe    od     om
    vecs[0]  = '{2'b01, 2'b01, 2'b00, 8'hA1, 8'h00, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{2'b01, 2'b01, 2'b00, 8'hA1, 8'h00, 3'd0, 3'd0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 8'hA2, 8'h00, 3'd0, 3'd0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1, 3'd0};
    vecs[3]  = '{2'b01, 2'b00, 2'b01, 8'hA3, 8'h00, 3'd5, 3'd0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA2, 3'd0};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 3'd5};
    vecs[5]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[6]  = '{2'b10, 2'b00, 2'b00, 8'h00, 8'hB9, 3'd0, 3'd0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[7]  = '{2'b10, 2'b00, 2'b00, 8'h00, 8'hBA, 3'd0, 3'd0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[9]  = '{2'b11, 2'b11, 2'b11, 8'hC1, 8'hD1, 3'd2, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[10] = '{2'b11, 2'b11, 2'b11, 8'hC1, 8'hD1, 3'd2, 3'd4, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[11] = '{2'b01, 2'b01, 2'b01, 8'hC1, 8'h00, 3'd2, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hD1, 3'd4};
    vecs[12] = '{2'b01, 2'b01, 2'b01, 8'hC1, 8'h00, 3'd2, 3'd0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC1, 3'd2};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};

    // Reset state, with non-sop words offered that must not be accepted during reset.
    drive_idle();
    in_val = 2'b11;
    pkt_bus.ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", 64'(pkt_bus.val), 64'(0));
    chk("rst_sop_eop", 64'({pkt_bus.sop, pkt_bus.eop}), 64'(0));
    chk("rst_data", pkt_bus.data, 64'(0));
    chk("rst_mod", 64'(pkt_bus.mod), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_orphan", 64'(orphan), 64'(0));
    @(negedge clk);
    drive_idle();
    rst = 1'b0;

    // Single packet, orphan drop, single-word packets on both channels.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_val  = vecs[i].val;
      in_sop  = vecs[i].sop;
      in_eop  = vecs[i].eop;
      in_data = {56'h0, vecs[i].d1, 56'h0, vecs[i].d0};
      in_mod  = {vecs[i].m1, vecs[i].m0};
      #1;
      $display("vec %0d: val=%b sop=%b eop=%b grant=%b rdy=%b orphan=%b out_val=%b out_data=%h",
               i, in_val, in_sop, in_eop, grant, in_ready, orphan, pkt_bus.val, pkt_bus.data);
      chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vecs[i].g));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
      chk($sformatf("v%0d_orphan", i), 64'(orphan), 64'(vecs[i].orph));
      chk($sformatf("v%0d_val", i), 64'(pkt_bus.val), 64'(vecs[i].oval));
      chk($sformatf("v%0d_sop_eop", i), 64'({pkt_bus.sop, pkt_bus.eop}), 64'({vecs[i].osop, vecs[i].oeop}));
      if (vecs[i].oval) begin
        chk($sformatf("v%0d_data", i), pkt_bus.data, 64'(vecs[i].od));
        chk($sformatf("v%0d_mod", i), 64'(pkt_bus.mod), 64'(vecs[i].om));
      end
    end

    // Fairness: both channels always requesting, 4-word packets, one bubble between packets.
    do_reset();
    stream(4, 2, 2, 1'b0, 16);
    chk("t2_count", 64'(got_q.size()), 64'(16));
    if (got_q.size() > 0) chk("t2_latency", 64'(cyc_q[0]), 64'(2));
    for (int i = 0; i < got_q.size(); i++) begin
      exp_w = mk_word((i / 4) % 2, i / 8, i % 4, 4);
      chk_word($sformatf("t2_w%0d", i), got_q[i], exp_w);
      if (i > 0)
        chk($sformatf("t2_gap%0d", i), 64'(cyc_q[i] - cyc_q[i-1]), 64'(got_q[i-1].eop ? 2 : 1));
    end

    // Back-pressure toggling 1010 on a granted packet while ch1 waits with sop.
    do_reset();
    stream(6, 1, 1, 1'b1, 6);
    chk("t3_count", 64'(got_q.size()), 64'(6));
    chk("t3_rdy1_while_ch0", 64'(r1_bad), 64'(0));
    for (int i = 0; i < got_q.size(); i++)
      chk_word($sformatf("t3_w%0d", i), got_q[i], mk_word(0, 0, i, 6));

    // Reset in the middle of a 5-word packet, then a fresh packet on ch0.
    do_reset();
    fired = 0;
    for (int c = 0; c < 20 && fired < 2; c++) begin
      @(negedge clk);
      exp_w   = mk_word(0, 0, fired, 5);
      in_val  = 2'b01;
      in_sop  = {1'b0, exp_w.sop};
      in_eop  = {1'b0, exp_w.eop};
      in_data = {64'h0, exp_w.data};
      in_mod  = {3'd0, exp_w.mod};
      #1;
      if (in_ready[0]) fired++;
    end
    chk("t6_fired", 64'(fired), 64'(2));
    @(negedge clk);
    exp_w   = mk_word(0, 0, 2, 5);
    in_data = {64'h0, exp_w.data};
    in_sop  = 2'b00;
    rst = 1'b1;
    #1;
    chk("t6_rst_val", 64'(pkt_bus.val), 64'(0));
    chk("t6_rst_data", pkt_bus.data, 64'(0));
    chk("t6_rst_grant", 64'(grant), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t6_rst_orphan", 64'(orphan), 64'(0));
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    stream(3, 1, 1, 1'b0, 3);
    chk("t6_count", 64'(got_q.size()), 64'(3));
    for (int i = 0; i < got_q.size(); i++)
      chk_word($sformatf("t6_w%0d", i), got_q[i], mk_word(0, 0, i, 3));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
